// File: rtl/rv32i_pkg.sv
`default_nettype none
// ============================================================================
// Package     : rv32i_pkg
// Description : Shared encodings for the RV32I multi-cycle control path:
//               FSM state codes, base opcodes, datapath mux selects, ALU
//               operation codes and the branch-condition helper.
// Revision    : 1.0 - initial release
// ============================================================================
package rv32i_pkg;

    // FSM state encoding (also driven out on the state port)
    localparam logic [2:0] c_ST_FETCH  = 3'b000;
    localparam logic [2:0] c_ST_DECODE = 3'b001;
    localparam logic [2:0] c_ST_EXEC   = 3'b010;
    localparam logic [2:0] c_ST_MEM    = 3'b011;
    localparam logic [2:0] c_ST_WB     = 3'b100;
    localparam logic [2:0] c_ST_TRAP   = 3'b101;

    // RV32I base opcodes (IR[6:0])
    localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
    localparam logic [6:0] c_OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OPC_JAL    = 7'b1101111;
    localparam logic [6:0] c_OPC_JALR   = 7'b1100111;
    localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OPC_STORE  = 7'b0100011;
    localparam logic [6:0] c_OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] c_OPC_OP     = 7'b0110011;

    // Next-PC select
    localparam logic [1:0] c_SELPC_ALU    = 2'b00;
    localparam logic [1:0] c_SELPC_JUMP   = 2'b01;
    localparam logic [1:0] c_SELPC_BRANCH = 2'b10;
    localparam logic [1:0] c_SELPC_PC4    = 2'b11;

    // Write-back select
    localparam logic [1:0] c_WB_PC4  = 2'b00;
    localparam logic [1:0] c_WB_DM   = 2'b01;
    localparam logic [1:0] c_WB_ALU  = 2'b10;
    localparam logic [1:0] c_WB_UIMM = 2'b11;

    // ALU operand selects
    localparam logic [1:0] c_OP1_PC  = 2'b00;
    localparam logic [1:0] c_OP1_RS1 = 2'b10;
    localparam logic [1:0] c_OP2_RS2 = 2'b00;
    localparam logic [1:0] c_OP2_IMM = 2'b10;

    // Immediate formats
    localparam logic [2:0] c_IMM_I = 3'b000;
    localparam logic [2:0] c_IMM_S = 3'b001;
    localparam logic [2:0] c_IMM_B = 3'b010;
    localparam logic [2:0] c_IMM_U = 3'b011;
    localparam logic [2:0] c_IMM_J = 3'b100;

    // ALU operation used for every address / PC computation
    localparam logic [3:0] c_ALU_ADD = 4'b0000;

    // ADDI x0,x0,0 - the IR contents after reset
    localparam logic [31:0] c_NOP_INSN = 32'h0000_0013;

    // Instruction classes produced by the decoder
    typedef enum logic [3:0] {
        CLS_ALU_R   = 4'd0,
        CLS_ALU_I   = 4'd1,
        CLS_LUI     = 4'd2,
        CLS_AUIPC   = 4'd3,
        CLS_JAL     = 4'd4,
        CLS_JALR    = 4'd5,
        CLS_BRANCH  = 4'd6,
        CLS_LOAD    = 4'd7,
        CLS_STORE   = 4'd8,
        CLS_ILLEGAL = 4'd9
    } insn_class_e;

    // Branch condition from funct3 and the rs1/rs2 comparator flags.
    // The reserved funct3 codes 010/011 are treated as never taken.
    function automatic logic branch_taken(input logic [2:0] funct3,
                                          input logic       eq,
                                          input logic       lt,
                                          input logic       ltu);
        logic taken;
        case (funct3)
            3'b000:  taken = eq;
            3'b001:  taken = ~eq;
            3'b100:  taken = lt;
            3'b101:  taken = ~lt;
            3'b110:  taken = ltu;
            3'b111:  taken = ~ltu;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rv32i_decode.sv
`default_nettype none
// ============================================================================
// Module      : rv32i_decode
// Description : Purely combinational IR decoder: instruction class,
//               immediate format and ALU operation.
// Revision    : 1.0 - initial release
// ============================================================================
module rv32i_decode
    import rv32i_pkg::*;
(
    input  logic [31:0] ir_i,
    output insn_class_e cls_o,
    output logic [2:0]  imm_sel_o,
    output logic [3:0]  alu_ctrl_o
);

    logic [2:0] w_funct3;
    logic       w_funct7_5;
    logic       w_unused;

    assign w_funct3   = ir_i[14:12];
    assign w_funct7_5 = ir_i[30];
    // Register and immediate fields are consumed by the datapath, not here
    assign w_unused   = ^{ir_i[31], ir_i[29:15], ir_i[11:7]};

    // Classify the opcode and pick immediate format / ALU operation
    always_comb begin
        cls_o      = CLS_ILLEGAL;
        imm_sel_o  = c_IMM_I;
        alu_ctrl_o = c_ALU_ADD;
        case (ir_i[6:0])
            c_OPC_OP: begin
                cls_o      = CLS_ALU_R;
                alu_ctrl_o = {w_funct7_5, w_funct3};
            end
            c_OPC_OPIMM: begin
                // Only SRAI uses bit 30 as an opcode bit; elsewhere it is
                // immediate data and must not turn ADDI into SUB.
                cls_o      = CLS_ALU_I;
                alu_ctrl_o = {(w_funct3 == 3'b101) & w_funct7_5, w_funct3};
            end
            c_OPC_LUI: begin
                cls_o     = CLS_LUI;
                imm_sel_o = c_IMM_U;
            end
            c_OPC_AUIPC: begin
                cls_o     = CLS_AUIPC;
                imm_sel_o = c_IMM_U;
            end
            c_OPC_JAL: begin
                cls_o     = CLS_JAL;
                imm_sel_o = c_IMM_J;
            end
            c_OPC_JALR: begin
                cls_o     = CLS_JALR;
                imm_sel_o = c_IMM_I;
            end
            c_OPC_BRANCH: begin
                cls_o     = CLS_BRANCH;
                imm_sel_o = c_IMM_B;
            end
            c_OPC_LOAD: begin
                cls_o     = CLS_LOAD;
                imm_sel_o = c_IMM_I;
            end
            c_OPC_STORE: begin
                cls_o     = CLS_STORE;
                imm_sel_o = c_IMM_S;
            end
            default: begin
                cls_o = CLS_ILLEGAL;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/rv32i_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module      : rv32i_ctrl_fsm
// Description : Multi-cycle RV32I control FSM (FETCH/DECODE/EXEC/MEM/WB/TRAP).
//               All decode outputs come from the registered IR.
//               Build option ILLEGAL_INSN_TRAP_EN: unknown opcodes enter a
//               sticky TRAP state; otherwise they retire as a NOP.
// Revision    : 1.0 - initial release
// ============================================================================
module rv32i_ctrl_fsm
    import rv32i_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] insn,
    input  logic        br_eq,
    input  logic        br_lt,
    input  logic        br_ltu,
    input  logic        dmem_ready,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  selpc,
    output logic [1:0]  wbsel,
    output logic [1:0]  op1_sel,
    output logic [1:0]  op2_sel,
    output logic [2:0]  imm_sel,
    output logic [3:0]  alu_ctrl,
    output logic        reg_we,
    output logic        dmem_en,
    output logic        dmem_we,
    output logic [1:0]  dmem_size,
    output logic [2:0]  state,
    output logic        retire,
    output logic        illegal
);

    logic [2:0]  state_q;
    logic [2:0]  state_d;
    logic [31:0] ir_q;
    logic [1:0]  selpc_q;      // jump target select carried from EXEC to WB

    insn_class_e w_cls;
    logic        w_is_jump;
    logic        w_ir_we;
    logic        w_pc_we;
    logic        w_retire;
    logic        w_reg_we;
    logic        w_dmem_en;
    logic        w_dmem_we;
    logic [1:0]  w_selpc;

    rv32i_decode u_decode (
        .ir_i       (ir_q),
        .cls_o      (w_cls),
        .imm_sel_o  (imm_sel),
        .alu_ctrl_o (alu_ctrl)
    );

    assign w_is_jump = (w_cls == CLS_JAL) || (w_cls == CLS_JALR);
    assign dmem_size = ir_q[13:12];
    assign state     = state_q;

    // Datapath operand and write-back selects derived from the IR class
    always_comb begin
        op1_sel = c_OP1_RS1;
        op2_sel = c_OP2_IMM;
        wbsel   = c_WB_ALU;
        case (w_cls)
            CLS_ALU_R:  op2_sel = c_OP2_RS2;
            CLS_LUI: begin
                op1_sel = c_OP1_PC;
                wbsel   = c_WB_UIMM;
            end
            CLS_AUIPC:  op1_sel = c_OP1_PC;
            CLS_JAL: begin
                op1_sel = c_OP1_PC;
                wbsel   = c_WB_PC4;
            end
            CLS_JALR:   wbsel   = c_WB_PC4;
            CLS_BRANCH: op1_sel = c_OP1_PC;
            CLS_LOAD:   wbsel   = c_WB_DM;
            default:    op2_sel = c_OP2_IMM;
        endcase
    end

    // Next-state logic and raw (pre-reset-gating) strobes
    always_comb begin
        state_d   = state_q;
        w_ir_we   = 1'b0;
        w_pc_we   = 1'b0;
        w_retire  = 1'b0;
        w_reg_we  = 1'b0;
        w_dmem_en = 1'b0;
        w_dmem_we = 1'b0;
        w_selpc   = c_SELPC_PC4;
        case (state_q)
            c_ST_FETCH: begin
                w_ir_we = 1'b1;
                state_d = c_ST_DECODE;
            end
            c_ST_DECODE: begin
`ifdef ILLEGAL_INSN_TRAP_EN
                state_d = (w_cls == CLS_ILLEGAL) ? c_ST_TRAP : c_ST_EXEC;
`else
                state_d = c_ST_EXEC;
`endif
            end
            c_ST_EXEC: begin
                case (w_cls)
                    CLS_BRANCH: begin
                        w_pc_we  = 1'b1;
                        w_retire = 1'b1;
                        w_selpc  = branch_taken(ir_q[14:12], br_eq, br_lt, br_ltu)
                                   ? c_SELPC_BRANCH : c_SELPC_PC4;
                        state_d  = c_ST_FETCH;
                    end
                    CLS_JAL: begin
                        w_selpc = c_SELPC_JUMP;
                        state_d = c_ST_WB;
                    end
                    CLS_JALR: begin
                        w_selpc = c_SELPC_ALU;
                        state_d = c_ST_WB;
                    end
                    CLS_LOAD, CLS_STORE: begin
                        state_d = c_ST_MEM;
                    end
                    CLS_ILLEGAL: begin
                        // Unknown opcode retires as a NOP (only reachable
                        // when the trap option is not built in)
                        w_pc_we  = 1'b1;
                        w_retire = 1'b1;
                        state_d  = c_ST_FETCH;
                    end
                    default: begin
                        state_d = c_ST_WB;
                    end
                endcase
            end
            c_ST_MEM: begin
                w_dmem_en = 1'b1;
                w_dmem_we = (w_cls == CLS_STORE);
                if (dmem_ready) begin
                    if (w_cls == CLS_STORE) begin
                        w_pc_we  = 1'b1;
                        w_retire = 1'b1;
                        state_d  = c_ST_FETCH;
                    end else begin
                        state_d  = c_ST_WB;
                    end
                end
            end
            c_ST_WB: begin
                w_reg_we = (ir_q[11:7] != 5'd0);
                w_pc_we  = 1'b1;
                w_retire = 1'b1;
                w_selpc  = w_is_jump ? selpc_q : c_SELPC_PC4;
                state_d  = c_ST_FETCH;
            end
            c_ST_TRAP: begin
                state_d = c_ST_TRAP;
            end
            default: begin
                state_d = c_ST_FETCH;
            end
        endcase
    end

    // Reset dominates every strobe so an abandoned instruction leaves no trace
    assign ir_we   = w_ir_we   & ~reset;
    assign pc_we   = w_pc_we   & ~reset;
    assign retire  = w_retire  & ~reset;
    assign reg_we  = w_reg_we  & ~reset;
    assign dmem_en = w_dmem_en & ~reset;
    assign dmem_we = w_dmem_we & ~reset;
    assign selpc   = w_selpc;

`ifdef ILLEGAL_INSN_TRAP_EN
    assign illegal = (state_q == c_ST_TRAP);
`else
    assign illegal = 1'b0;
`endif

    // State, IR capture and jump-select latch
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= c_ST_FETCH;
            ir_q    <= c_NOP_INSN;
            selpc_q <= c_SELPC_PC4;
        end else begin
            state_q <= state_d;
            if (w_ir_we) begin
                ir_q <= insn;
            end
            if (state_q == c_ST_EXEC) begin
                selpc_q <= w_selpc;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rv32i_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_rv32i_ctrl_fsm
// Description : Scoreboard bench for rv32i_ctrl_fsm. A driver issues directed
//               and random instructions and queues the reference result; a
//               monitor pops and compares on every retire.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rv32i_ctrl_fsm;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] insn;
    logic        br_eq, br_lt, br_ltu;
    logic        dmem_ready;
    logic        ir_we, pc_we, reg_we, dmem_en, dmem_we, retire, illegal;
    logic [1:0]  selpc, wbsel, op1_sel, op2_sel, dmem_size;
    logic [2:0]  imm_sel, state;
    logic [3:0]  alu_ctrl;

    int n_tests = 0;
    int n_fail  = 0;
    bit mon_en  = 1'b0;

    typedef struct {
        int         cycles;
        int         reg_we_n;
        logic [1:0] selpc;
        bit         chk_wb;   logic [1:0] wbsel;
        bit         chk_alu;  logic [3:0] alu;
        bit         chk_imm;  logic [2:0] imm;
        bit         chk_op1;  logic [1:0] op1;
        bit         chk_op2;  logic [1:0] op2;
        bit         chk_size; logic [1:0] size;
        int         mem_cyc;
        int         we_cyc;
    } exp_t;

    exp_t exp_q[$];

    rv32i_ctrl_fsm dut (
        .clk        (clk),
        .reset      (reset),
        .insn       (insn),
        .br_eq      (br_eq),
        .br_lt      (br_lt),
        .br_ltu     (br_ltu),
        .dmem_ready (dmem_ready),
        .ir_we      (ir_we),
        .pc_we      (pc_we),
        .selpc      (selpc),
        .wbsel      (wbsel),
        .op1_sel    (op1_sel),
        .op2_sel    (op2_sel),
        .imm_sel    (imm_sel),
        .alu_ctrl   (alu_ctrl),
        .reg_we     (reg_we),
        .dmem_en    (dmem_en),
        .dmem_we    (dmem_we),
        .dmem_size  (dmem_size),
        .state      (state),
        .retire     (retire),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic bit is_legal(input logic [6:0] o);
        return o inside {7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111, 7'b1101111,
                         7'b1100111, 7'b1100011, 7'b0000011, 7'b0100011};
    endfunction

    // Reference: what one instruction should look like from fetch to retire,
    // given the rs1/rs2 values and the number of memory wait cycles.
    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] a,
                                   input logic [31:0] b, input int w);
        exp_t       e;
        logic [2:0] f3;
        bit         writes;
        bit         taken;
        f3     = ins[14:12];
        writes = 1'b0;
        e      = '{cycles: 3, reg_we_n: 0, selpc: 2'b11, chk_wb: 0, wbsel: 2'b00,
                   chk_alu: 1, alu: 4'b0000, chk_imm: 0, imm: 3'b000, chk_op1: 0,
                   op1: 2'b00, chk_op2: 0, op2: 2'b00, chk_size: 0, size: 2'b00,
                   mem_cyc: 0, we_cyc: 0};
        case (ins[6:0])
            7'b0110011: begin
                e.cycles = 4; writes = 1; e.wbsel = 2'b10; e.alu = {ins[30], f3};
                e.chk_op1 = 1; e.op1 = 2'b10; e.chk_op2 = 1; e.op2 = 2'b00;
            end
            7'b0010011: begin
                e.cycles = 4; writes = 1; e.wbsel = 2'b10;
                e.alu = (f3 == 3'd5) ? {ins[30], f3} : {1'b0, f3};
                e.chk_op1 = 1; e.op1 = 2'b10; e.chk_op2 = 1; e.op2 = 2'b10;
                e.chk_imm = 1; e.imm = 3'd0;
            end
            7'b0110111: begin
                e.cycles = 4; writes = 1; e.wbsel = 2'b11; e.chk_alu = 0;
                e.chk_imm = 1; e.imm = 3'd3;
            end
            7'b0010111: begin
                e.cycles = 4; writes = 1; e.wbsel = 2'b10;
                e.chk_op1 = 1; e.op1 = 2'b00; e.chk_op2 = 1; e.op2 = 2'b10;
                e.chk_imm = 1; e.imm = 3'd3;
            end
            7'b1101111: begin
                e.cycles = 4; writes = 1; e.wbsel = 2'b00; e.selpc = 2'b01;
                e.chk_imm = 1; e.imm = 3'd4;
            end
            7'b1100111: begin
                e.cycles = 4; writes = 1; e.wbsel = 2'b00; e.selpc = 2'b00;
                e.chk_op1 = 1; e.op1 = 2'b10; e.chk_op2 = 1; e.op2 = 2'b10;
                e.chk_imm = 1; e.imm = 3'd0;
            end
            7'b1100011: begin
                case (f3)
                    3'd0: taken = (a == b);
                    3'd1: taken = (a != b);
                    3'd4: taken = ($signed(a) <  $signed(b));
                    3'd5: taken = ($signed(a) >= $signed(b));
                    3'd6: taken = (a <  b);
                    3'd7: taken = (a >= b);
                    default: taken = 1'b0;
                endcase
                e.cycles = 3; e.selpc = taken ? 2'b10 : 2'b11;
                e.chk_imm = 1; e.imm = 3'd2;
            end
            7'b0000011: begin
                e.cycles = 5 + w; writes = 1; e.wbsel = 2'b01; e.mem_cyc = 1 + w;
                e.chk_op2 = 1; e.op2 = 2'b10; e.chk_imm = 1; e.imm = 3'd0;
                e.chk_size = 1; e.size = f3[1:0];
            end
            7'b0100011: begin
                e.cycles = 4 + w; e.mem_cyc = 1 + w; e.we_cyc = 1 + w;
                e.chk_op2 = 1; e.op2 = 2'b10; e.chk_imm = 1; e.imm = 3'd1;
                e.chk_size = 1; e.size = f3[1:0];
            end
            default: begin
                e.cycles = 3; e.chk_alu = 0;
            end
        endcase
        e.chk_wb   = writes;
        e.reg_we_n = (writes && ins[11:7] != 5'd0) ? 1 : 0;
        return e;
    endfunction

    // Driver: queue the expectation, then hold the instruction for its duration
    task automatic run_insn(input logic [31:0] ins, input logic [31:0] a,
                            input logic [31:0] b, input int w);
        exp_t e;
        e = model(ins, a, b, w);
        exp_q.push_back(e);
        insn   = ins;
        br_eq  = (a == b);
        br_lt  = ($signed(a) < $signed(b));
        br_ltu = (a < b);
        for (int c = 0; c < e.cycles; c++) begin
            dmem_ready = !(c >= 3 && c < 3 + w);
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: accumulate per-instruction strobe activity, check on retire
    initial begin
        int   cyc, n_en, n_we, n_reg, n_pc;
        exp_t e;
        cyc = 0; n_en = 0; n_we = 0; n_reg = 0; n_pc = 0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (ir_we) begin
                    cyc = 1; n_en = 0; n_we = 0; n_reg = 0; n_pc = 0;
                end else begin
                    cyc++;
                end
                n_en  += int'(dmem_en);
                n_we  += int'(dmem_we);
                n_reg += int'(reg_we);
                n_pc  += int'(pc_we);
                if (retire) begin
                    if (exp_q.size() == 0) begin
                        chk("retire_unexpected", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("cycles",     32'(cyc),      32'(e.cycles));
                        chk("pc_we_cnt",  32'(n_pc),     32'd1);
                        chk("pc_we",      32'(pc_we),    32'd1);
                        chk("reg_we_cnt", 32'(n_reg),    32'(e.reg_we_n));
                        chk("selpc",      32'(selpc),    32'(e.selpc));
                        chk("mem_cyc",    32'(n_en),     32'(e.mem_cyc));
                        chk("we_cyc",     32'(n_we),     32'(e.we_cyc));
                        chk("illegal",    32'(illegal),  32'd0);
                        if (e.chk_wb)   chk("wbsel",     32'(wbsel),     32'(e.wbsel));
                        if (e.chk_alu)  chk("alu_ctrl",  32'(alu_ctrl),  32'(e.alu));
                        if (e.chk_imm)  chk("imm_sel",   32'(imm_sel),   32'(e.imm));
                        if (e.chk_op1)  chk("op1_sel",   32'(op1_sel),   32'(e.op1));
                        if (e.chk_op2)  chk("op2_sel",   32'(op2_sel),   32'(e.op2));
                        if (e.chk_size) chk("dmem_size", 32'(dmem_size), 32'(e.size));
                    end
                end
            end
        end
    end

    // Stimulus
    initial begin
        logic [31:0] ins, a, b;
        logic [6:0]  opc;
        int          w, k;

        reset = 1'b1; insn = 32'd0; br_eq = 1'b0; br_lt = 1'b0; br_ltu = 1'b0;
        dmem_ready = 1'b1;
        repeat (3) @(posedge clk);

        // First cycle after reset: FETCH with only ir_we active
        #1 reset = 1'b0; insn = 32'h0020A023; dmem_ready = 1'b0;
        @(negedge clk);
        chk("rst_state",   32'(state), 32'd0);
        chk("rst_ir_we",   32'(ir_we), 32'd1);
        chk("rst_strobes", 32'({pc_we, reg_we, dmem_en, dmem_we, retire}), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);

        // Store reaches MEM, then reset collides with dmem_ready
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("sw_mem_state", 32'(state), 32'd3);
        chk("sw_mem_en_we", 32'({dmem_en, dmem_we}), 32'd3);
        @(posedge clk);
        #1 dmem_ready = 1'b1; reset = 1'b1;
        @(negedge clk);
        chk("sw_rst_strobes", 32'({pc_we, retire, dmem_we, reg_we}), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        chk("sw_rst_next", 32'(state), 32'd0);

        // Scoreboarded stream: directed cases first, then random
        mon_en = 1'b1;
        run_insn(32'h00500093, 32'd0, 32'd0, 0);            // ADDI x1,x0,5
        run_insn(32'h0000A103, 32'd0, 32'd0, 3);            // LW x2,0(x1), 3 waits
        run_insn(32'h00000463, 32'd7, 32'd7, 0);            // BEQ taken
        run_insn(32'h00000463, 32'd1, 32'd2, 0);            // BEQ not taken
        run_insn(32'h0020A023, 32'd0, 32'd0, 0);            // SW, no wait
        run_insn(32'h0020A023, 32'd0, 32'd0, 2);            // SW, 2 waits
        run_insn(32'h00000013, 32'd0, 32'd0, 0);            // NOP, rd=0
`ifndef ILLEGAL_INSN_TRAP_EN
        run_insn(32'hFFFFFFFF, 32'd0, 32'd0, 0);            // unknown opcode
`endif
        for (int n = 0; n < 300; n++) begin
`ifdef ILLEGAL_INSN_TRAP_EN
            k = $urandom_range(0, 8);
`else
            k = $urandom_range(0, 9);
`endif
            case (k)
                0: opc = 7'b0110011;
                1: opc = 7'b0010011;
                2: opc = 7'b0110111;
                3: opc = 7'b0010111;
                4: opc = 7'b1101111;
                5: opc = 7'b1100111;
                6: opc = 7'b1100011;
                7: opc = 7'b0000011;
                8: opc = 7'b0100011;
                default: begin
                    opc = 7'($urandom_range(0, 127));
                    while (is_legal(opc)) opc = 7'($urandom_range(0, 127));
                end
            endcase
            ins = $urandom;
            ins[6:0] = opc;
            if ($urandom_range(0, 3) == 0) ins[11:7] = 5'd0;
            a = $urandom;
            b = ($urandom_range(0, 2) == 0) ? a : $urandom;
            w = (k == 7 || k == 8) ? $urandom_range(0, 3) : 0;
            run_insn(ins, a, b, w);
        end

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
        chk("drain", 32'(exp_q.size()), 32'd0);
        mon_en = 1'b0;

`ifdef ILLEGAL_INSN_TRAP_EN
        // Unknown opcode parks in TRAP until reset
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0; insn = 32'hFFFFFFFF; dmem_ready = 1'b1;
        repeat (2) @(posedge clk);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("trap_state",   32'(state),   32'd5);
            chk("trap_illegal", 32'(illegal), 32'd1);
            chk("trap_strobes", 32'({ir_we, pc_we, reg_we, dmem_en, dmem_we, retire}), 32'd0);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rv32i_ctrl_fsm.md
RV32I_CTRL_FSM -- requirements
Module: rv32i_ctrl_fsm

Interface
REQ-001 SHALL have these ports; reset is synchronous, active-high; the clock is clk:
- clk  in  1  clock
- reset  in  1  synchronous reset, active-high
- insn  in  32  program-memory output
- br_eq, br_lt, br_ltu  in  1 each  comparator flags for rs1/rs2
- dmem_ready  in  1  data-memory access complete
- ir_we  out  1  instruction register (IR) captured this cycle
- pc_we  out  1  PC update strobe
- selpc  out  2  next-PC select: 00 ALU_OUT (JALR), 01 jump target, 10 branch target, 11 pc4
- wbsel  out  2  write-back select: 00 pc4, 01 DM_OUT, 10 ALU_OUT, 11 U-immediate
- op1_sel  out  2  operand 1 select: 00 pc, 10 rs1
- op2_sel  out  2  operand 2 select: 00 rs2, 10 immediate
- imm_sel  out  3  immediate format: 000 I, 001 S, 010 B, 011 U, 100 J
- alu_ctrl  out  4  ALU operation: {funct7[5], funct3}, forced to ADD for address/PC computation
- reg_we, dmem_en, dmem_we  out  1 each  write and access strobes
- dmem_size  out  2  data access size, equal to funct3[1:0]
- state  out  3  current FSM state
- retire  out  1  instruction completed
- illegal  out  1  trap flag

Function
REQ-002 SHALL implement these states: FETCH=000, DECODE=001, EXEC=010, MEM=011, WB=100, TRAP=101.
REQ-003 FETCH: SHALL assert ir_we and capture insn into the internal IR; next state DECODE.
REQ-004 DECODE: SHALL classify IR[6:0]. Next state EXEC for every legal opcode; TRAP or EXEC-as-NOP per REQ-017/018.
REQ-005 All decode outputs SHALL come from the registered IR and state only, never directly from insn.
REQ-006 EXEC handling per instruction class:
- R/I-ALU: op1=rs1; op2=rs2 or imm(I); next state WB.
- LUI/AUIPC: next state WB.
- Load/store: alu_ctrl=ADD, op2=imm (I for loads, S for stores); next state MEM.
REQ-007 Branch in EXEC: SHALL assert pc_we and retire. selpc=10 when the funct3 condition (eq/ne/lt/ge/ltu/geu) holds on br_* flags, else 11. Next state FETCH.
REQ-008 JAL/JALR in EXEC: SHALL set selpc=01 or 00 respectively; next state WB, which writes pc4.
REQ-009 MEM: SHALL hold dmem_en=1 (and dmem_we=1 for stores) while dmem_ready=0. On dmem_ready=1, loads go to WB; stores assert pc_we (selpc=11) and retire, then go to FETCH.
REQ-010 WB: SHALL assert reg_we for one cycle. reg_we is suppressed when rd=0. SHALL assert pc_we and retire. selpc=11, except jumps use the selpc latched in EXEC. Next state FETCH.
REQ-011 Cycle counts with dmem_ready=1 SHALL be: ALU/LUI/AUIPC/JAL/JALR 4, branch 3, store 4, load 5. Each dmem_ready=0 cycle in MEM adds one.
REQ-012 pc_we, retire, reg_we and ir_we SHALL each be a single-cycle pulse, at most one per instruction (ir_we once per FETCH).
REQ-013 When reset and dmem_ready=1 coincide in MEM, reset SHALL win: no retire and no write.

Reset
REQ-014 When reset=1 at a clock edge: state=FETCH, IR=0x00000013 (NOP), illegal=0.
REQ-015 During the first cycle after reset, every strobe (pc_we, reg_we, dmem_en, dmem_we, retire) SHALL be 0. ir_we=1 in that cycle (the FETCH cycle).
REQ-016 Reset mid-instruction SHALL abandon the instruction with no partial register or memory write.

Configuration
REQ-017 With ILLEGAL_INSN_TRAP_EN defined, an unknown opcode SHALL send DECODE to TRAP. TRAP sets illegal=1, holds all strobes at 0, and is exited only by reset.
REQ-018 Without ILLEGAL_INSN_TRAP_EN, an unknown opcode SHALL be executed as a NOP: EXEC asserts pc_we (selpc=11) and retire, then FETCH. illegal is tied to 0.

Structure
REQ-019 The state encoding, opcode constants, and selpc/wbsel/op/imm/alu encodings SHALL live in the shared package rv32i_pkg.
REQ-020 Combinational IR decode SHALL be a sub-module rv32i_decode (IR to class, imm_sel, alu_ctrl). The FSM and strobes SHALL stay in rv32i_ctrl_fsm.

Verification
REQ-021 ADDI x1,x0,5 (0x00500093): states FETCH,DECODE,EXEC,WB. In WB: reg_we=1, wbsel=10, op2_sel=10, pc_we=1, selpc=11.
REQ-022 LW x2,0(x1) (0x0000A103) with dmem_ready low for 3 cycles: MEM lasts 4 cycles with dmem_en=1 and dmem_we=0. Then WB with wbsel=01; 8 cycles total.
REQ-023 BEQ x0,x0,+8 (0x00000463):
- br_eq=1: pc_we=1 and selpc=10 in EXEC, retire in cycle 3.
- br_eq=0: selpc=11.
REQ-024 Insn 0xFFFFFFFF:
- With ILLEGAL_INSN_TRAP_EN: state=101 and illegal=1, held for 10 cycles.
- Without it: retire after 3 cycles with no reg_we.
REQ-025 SW (0x0020A023) with reset asserted during MEM and dmem_ready=1 in the same cycle: dmem_we and pc_we never pulse after reset, and the next state is FETCH.
